// File: rtl/fpu_lzd_pkg.sv
// Shared types and constants for the pipelined leading-zero detector / normaliser.
package fpu_lzd_pkg;

    localparam int LZD_LATENCY   = 2;
    localparam int LZD_MAX_WIDTH = 128;
    localparam int LZD_MAX_POS_W = $clog2(LZD_MAX_WIDTH);

    typedef struct packed {
        logic [LZD_MAX_POS_W-1:0] pos;
        logic                     zero;
    } lzd_result_t;

    function automatic int lzd_pos_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/fpu_lzd_tree.sv
// Combinational leading-zero counter built by recursive halving down to 2-bit leaves.
module fpu_lzd_tree #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]         data,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     zero
);

    generate
        if (WIDTH == 2) begin : g_base
            assign zero  = ~(data[1] | data[0]);
            assign count = ~data[1];
        end else begin : g_split
            localparam int HALF = WIDTH / 2;

            logic [$clog2(HALF)-1:0] cnt_hi;
            logic [$clog2(HALF)-1:0] cnt_lo;
            logic                    zero_hi;
            logic                    zero_lo;

            fpu_lzd_tree #(.WIDTH(HALF)) u_hi (
                .data  (data[WIDTH-1:HALF]),
                .count (cnt_hi),
                .zero  (zero_hi)
            );

            fpu_lzd_tree #(.WIDTH(HALF)) u_lo (
                .data  (data[HALF-1:0]),
                .count (cnt_lo),
                .zero  (zero_lo)
            );

            // HALF is a power of two, so prefixing a 1 adds HALF to the lower count.
            assign zero  = zero_hi & zero_lo;
            assign count = zero_hi ? {1'b1, cnt_lo} : {1'b0, cnt_hi};
        end
    endgenerate

endmodule

// File: rtl/fpu_lzd_norm_pipe.sv
// Two-stage elastic pipeline: S1 registers per-half LZD results, S2 combines, shifts and drives the outputs.
module fpu_lzd_norm_pipe
    import fpu_lzd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int POS_W = lzd_pos_w(WIDTH),
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_norm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [POS_W-1:0] out_pos,
    output logic             out_zero,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int HALF   = WIDTH / 2;
    localparam int HPOS_W = $clog2(HALF);

    logic [HPOS_W-1:0] cnt_hi_c, cnt_lo_c;
    logic              zero_hi_c, zero_lo_c;

    fpu_lzd_tree #(.WIDTH(HALF)) u_lzd_hi (
        .data  (in_data[WIDTH-1:HALF]),
        .count (cnt_hi_c),
        .zero  (zero_hi_c)
    );

    fpu_lzd_tree #(.WIDTH(HALF)) u_lzd_lo (
        .data  (in_data[HALF-1:0]),
        .count (cnt_lo_c),
        .zero  (zero_lo_c)
    );

    logic              v1_q, v1_d;
    logic [WIDTH-1:0]  data1_q, data1_d;
    logic              norm1_q, norm1_d;
    logic [TAG_W-1:0]  tag1_q, tag1_d;
    logic [HPOS_W-1:0] cnt_hi1_q, cnt_hi1_d, cnt_lo1_q, cnt_lo1_d;
    logic              zero_hi1_q, zero_hi1_d, zero_lo1_q, zero_lo1_d;

    logic              v2_q, v2_d;
    logic [POS_W-1:0]  pos2_q, pos2_d;
    logic              zero2_q, zero2_d;
    logic [WIDTH-1:0]  data2_q, data2_d;
    logic [TAG_W-1:0]  tag2_q, tag2_d;

    logic              en1, en2;
    logic [POS_W-1:0]  pos_c;
    logic              zero_c;

    assign en2      = !v2_q || out_ready;
    assign en1      = !v1_q || en2;
    assign in_ready = en1;

    // Upper-half zero means the count continues into the lower half at offset HALF.
    always_comb begin
        pos_c  = '0;
        zero_c = 1'b0;
        if (!zero_hi1_q) begin
            pos_c = {1'b0, cnt_hi1_q};
        end else if (!zero_lo1_q) begin
            pos_c = {1'b1, cnt_lo1_q};
        end else begin
            zero_c = 1'b1;
        end
    end

    always_comb begin
        v1_d       = v1_q;
        data1_d    = data1_q;
        norm1_d    = norm1_q;
        tag1_d     = tag1_q;
        cnt_hi1_d  = cnt_hi1_q;
        cnt_lo1_d  = cnt_lo1_q;
        zero_hi1_d = zero_hi1_q;
        zero_lo1_d = zero_lo1_q;
        v2_d       = v2_q;
        pos2_d     = pos2_q;
        zero2_d    = zero2_q;
        data2_d    = data2_q;
        tag2_d     = tag2_q;

        if (en1) begin
            v1_d = in_valid;
            if (in_valid) begin
                data1_d    = in_data;
                norm1_d    = in_norm;
                tag1_d     = in_tag;
                cnt_hi1_d  = cnt_hi_c;
                cnt_lo1_d  = cnt_lo_c;
                zero_hi1_d = zero_hi_c;
                zero_lo1_d = zero_lo_c;
            end
        end

        if (en2) begin
            v2_d = v1_q;
            if (v1_q) begin
                pos2_d  = pos_c;
                zero2_d = zero_c;
                tag2_d  = tag1_q;
                if (zero_c) begin
                    data2_d = '0;
                end else if (norm1_q) begin
                    data2_d = data1_q << pos_c;
                end else begin
                    data2_d = data1_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            data1_q    <= '0;
            norm1_q    <= 1'b0;
            tag1_q     <= '0;
            cnt_hi1_q  <= '0;
            cnt_lo1_q  <= '0;
            zero_hi1_q <= 1'b0;
            zero_lo1_q <= 1'b0;
            v2_q       <= 1'b0;
            pos2_q     <= '0;
            zero2_q    <= 1'b0;
            data2_q    <= '0;
            tag2_q     <= '0;
        end else begin
            v1_q       <= v1_d;
            data1_q    <= data1_d;
            norm1_q    <= norm1_d;
            tag1_q     <= tag1_d;
            cnt_hi1_q  <= cnt_hi1_d;
            cnt_lo1_q  <= cnt_lo1_d;
            zero_hi1_q <= zero_hi1_d;
            zero_lo1_q <= zero_lo1_d;
            v2_q       <= v2_d;
            pos2_q     <= pos2_d;
            zero2_q    <= zero2_d;
            data2_q    <= data2_d;
            tag2_q     <= tag2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_pos   = pos2_q;
    assign out_zero  = zero2_q;
    assign out_data  = data2_q;
    assign out_tag   = tag2_q;

endmodule
